// File: rtl/msg_pkg.sv
// Shared constants for the game-message encoder: default message bytes,
// color payload bytes and the FSM state encoding.
package msg_pkg;

    localparam logic [7:0] DEF_START_BYTE  = 8'h53;
    localparam logic [7:0] DEF_CFG_HDR     = 8'h43;
    localparam logic [7:0] DEF_MOVE_BASE   = 8'h30;
    localparam logic [7:0] DEF_EOT_BYTE    = 8'h45;

    localparam logic [7:0] COLOR_RED_BYTE  = 8'h52;
    localparam logic [7:0] COLOR_BLUE_BYTE = 8'h42;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SEND = 1'b1;

    function automatic logic [7:0] color_byte(input logic red);
        return red ? COLOR_RED_BYTE : COLOR_BLUE_BYTE;
    endfunction

endpackage

// File: rtl/msg_encoder.sv
// Game-message encoder: latches start/config/move requests into pending
// slots and serialises the highest-priority pending message into a
// byte-wide fifo, one byte per cycle whenever the fifo has room.
//
//   state | meaning
//   IDLE  | no message in flight; picks next pending request (start > cfg > move)
//   SEND  | emitting shadow bytes 0..r_last, advancing on each accepted write
module msg_encoder
    import msg_pkg::*;
#(
    parameter logic [7:0] START_BYTE = DEF_START_BYTE,
    parameter logic [7:0] CFG_HDR    = DEF_CFG_HDR,
    parameter logic [7:0] MOVE_BASE  = DEF_MOVE_BASE,
    parameter logic [7:0] EOT_BYTE   = DEF_EOT_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_start,
    input  logic       send_cfg,
    input  logic [7:0] width,
    input  logic [7:0] length,
    input  logic       color_red,
    input  logic       move_valid,
    input  logic [2:0] move_dir,
    input  logic       move_last,
    input  logic       buf_full,
    output logic       wr_en,
    output logic [7:0] buf_in,
    output logic       busy,
    output logic       drop
);

    state_t          r_state;
    logic            r_start_pend;
    logic            r_cfg_pend;
    logic            r_move_pend;
    logic [7:0]      r_cfg_width;
    logic [7:0]      r_cfg_length;
    logic            r_cfg_red;
    logic [2:0]      r_move_dir;
    logic            r_move_last;
    logic [3:0][7:0] r_shadow;
    logic [1:0]      r_last;
    logic [1:0]      r_idx;
    logic            r_drop;

    logic            w_idle;
    logic            w_sel_start;
    logic            w_sel_cfg;
    logic            w_sel_move;
    logic            w_wr_en;
    logic [7:0]      w_move_byte;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_sel_start = w_idle & r_start_pend;
    assign w_sel_cfg   = w_idle & ~r_start_pend & r_cfg_pend;
    assign w_sel_move  = w_idle & ~r_start_pend & ~r_cfg_pend & r_move_pend;
    assign w_wr_en     = (r_state == ST_SEND) & ~buf_full;
    assign w_move_byte = MOVE_BASE + {5'b0, r_move_dir};

    assign wr_en  = w_wr_en;
    assign buf_in = (r_state == ST_SEND) ? r_shadow[r_idx] : 8'h00;
    assign busy   = (r_state == ST_SEND) | r_start_pend | r_cfg_pend | r_move_pend;
    assign drop   = r_drop;

    // Pending slots: a new request sets its flag (overwriting payload); selection clears it.
    // A request landing on the same edge its slot is consumed is not a loss, so no drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_pend <= 1'b0;
            r_cfg_pend   <= 1'b0;
            r_move_pend  <= 1'b0;
            r_cfg_width  <= 8'h00;
            r_cfg_length <= 8'h00;
            r_cfg_red    <= 1'b0;
            r_move_dir   <= 3'd0;
            r_move_last  <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= (send_start & r_start_pend & ~w_sel_start) |
                      (send_cfg   & r_cfg_pend   & ~w_sel_cfg)   |
                      (move_valid & r_move_pend  & ~w_sel_move);

            if (send_start)
                r_start_pend <= 1'b1;
            else if (w_sel_start)
                r_start_pend <= 1'b0;

            if (send_cfg) begin
                r_cfg_pend   <= 1'b1;
                r_cfg_width  <= width;
                r_cfg_length <= length;
                r_cfg_red    <= color_red;
            end else if (w_sel_cfg) begin
                r_cfg_pend   <= 1'b0;
            end

            if (move_valid) begin
                r_move_pend  <= 1'b1;
                r_move_dir   <= move_dir;
                r_move_last  <= move_last;
            end else if (w_sel_move) begin
                r_move_pend  <= 1'b0;
            end
        end
    end

    // FSM: load the selected message into the shadow, then walk its bytes as the fifo accepts them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shadow <= '0;
            r_last   <= 2'd0;
            r_idx    <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idx <= 2'd0;
                    if (w_sel_start) begin
                        r_shadow <= {8'h00, 8'h00, 8'h00, START_BYTE};
                        r_last   <= 2'd0;
                        r_state  <= ST_SEND;
                    end else if (w_sel_cfg) begin
                        r_shadow <= {color_byte(r_cfg_red), r_cfg_length, r_cfg_width, CFG_HDR};
                        r_last   <= 2'd3;
                        r_state  <= ST_SEND;
                    end else if (w_sel_move) begin
                        r_shadow <= {8'h00, 8'h00, EOT_BYTE, w_move_byte};
                        r_last   <= r_move_last ? 2'd1 : 2'd0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_wr_en) begin
                        if (r_idx == r_last) begin
                            r_idx   <= 2'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_encoder.sv
// Testbench for msg_encoder: directed scenarios plus randomized traffic,
// every cycle checked against a message-level queue model.
module tb_msg_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_start;
    logic       send_cfg;
    logic [7:0] width;
    logic [7:0] length;
    logic       color_red;
    logic       move_valid;
    logic [2:0] move_dir;
    logic       move_last;
    logic       buf_full;
    logic       wr_en;
    logic [7:0] buf_in;
    logic       busy;
    logic       drop;

    always #5 clk = ~clk;

    msg_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .send_start (send_start),
        .send_cfg   (send_cfg),
        .width      (width),
        .length     (length),
        .color_red  (color_red),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_last  (move_last),
        .buf_full   (buf_full),
        .wr_en      (wr_en),
        .buf_in     (buf_in),
        .busy       (busy),
        .drop       (drop)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending requests and the bytes of the message in flight.
    bit         m_start, m_cfg, m_move, m_drop;
    logic [7:0] m_w, m_l;
    bit         m_red;
    logic [2:0] m_dir;
    bit         m_last;
    logic [7:0] m_cur[$];

    logic [7:0] wlog[$];
    logic [7:0] exp_q[$];
    int         drop_cnt;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit s0 = m_start, c0 = m_cfg, v0 = m_move;
        bit tk_s = 0, tk_c = 0, tk_m = 0;
        if (rst) begin
            m_start = 0; m_cfg = 0; m_move = 0; m_drop = 0;
            m_cur.delete();
            return;
        end
        if (m_cur.size() == 0) begin
            if (m_start) begin
                tk_s = 1; m_start = 0;
                m_cur.push_back(8'h53);
            end else if (m_cfg) begin
                tk_c = 1; m_cfg = 0;
                m_cur.push_back(8'h43);
                m_cur.push_back(m_w);
                m_cur.push_back(m_l);
                m_cur.push_back(m_red ? 8'h52 : 8'h42);
            end else if (m_move) begin
                tk_m = 1; m_move = 0;
                m_cur.push_back(8'h30 + 8'(m_dir));
                if (m_last) m_cur.push_back(8'h45);
            end
        end else if (!buf_full) begin
            void'(m_cur.pop_front());
        end
        m_drop = (send_start && s0 && !tk_s) || (send_cfg && c0 && !tk_c) ||
                 (move_valid && v0 && !tk_m);
        if (send_start) m_start = 1;
        if (send_cfg) begin
            m_cfg = 1; m_w = width; m_l = length; m_red = color_red;
        end
        if (move_valid) begin
            m_move = 1; m_dir = move_dir; m_last = move_last;
        end
    endtask

    task automatic tick();
        bit exp_wr;
        @(negedge clk);
        exp_wr = (m_cur.size() > 0) && !buf_full;
        check("wr_en", 8'(wr_en), 8'(exp_wr));
        if (exp_wr) check("buf_in", buf_in, m_cur[0]);
        check("busy", 8'(busy), 8'((m_cur.size() > 0) || m_start || m_cfg || m_move));
        check("drop", 8'(drop), 8'(m_drop));
        if (wr_en) wlog.push_back(buf_in);
        if (drop) drop_cnt++;
        @(posedge clk);
        model_step();
        #1;
        send_start = 0;
        send_cfg   = 0;
        move_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 8'(wlog.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            check(tag, wlog[i], exp_q[i]);
    endtask

    task automatic clear_log();
        wlog.delete();
        drop_cnt = 0;
    endtask

    initial begin
        rst = 1; send_start = 0; send_cfg = 0; move_valid = 0;
        width = 0; length = 0; color_red = 0; move_dir = 0; move_last = 0;
        buf_full = 0;
        m_start = 0; m_cfg = 0; m_move = 0; m_drop = 0;
        m_w = 0; m_l = 0; m_red = 0; m_dir = 0; m_last = 0;
        drop_cnt = 0;
        @(posedge clk); #1;
        idle(2);
        rst = 0;
        idle(2);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_wr_en", 8'(wr_en), 8'd0);

        // Config message, latency and completion
        clear_log();
        send_cfg = 1; width = 8'd9; length = 8'd13; color_red = 1;
        tick();
        idle(6);
        exp_q = '{8'h43, 8'h09, 8'h0D, 8'h52};
        check_log("cfg_basic");

        // Move with and without end-of-turn
        clear_log();
        move_valid = 1; move_dir = 3'd5; move_last = 1;
        tick();
        idle(5);
        exp_q = '{8'h35, 8'h45};
        check_log("move_last1");
        clear_log();
        move_valid = 1; move_dir = 3'd5; move_last = 0;
        tick();
        idle(4);
        exp_q = '{8'h35};
        check_log("move_last0");

        // Simultaneous requests
        clear_log();
        send_start = 1; send_cfg = 1; width = 8'h21; length = 8'h22; color_red = 0;
        move_valid = 1; move_dir = 3'd2; move_last = 0;
        tick();
        idle(14);
        exp_q = '{8'h53, 8'h43, 8'h21, 8'h22, 8'h42, 8'h32};
        check_log("simul");
        check("simul_drops", 8'(drop_cnt), 8'd0);

        // Back-pressure holds width on buf_in
        clear_log();
        send_cfg = 1; width = 8'h07; length = 8'h03; color_red = 0;
        tick();
        idle(2);
        buf_full = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_hold", buf_in, 8'h07);
        end
        buf_full = 0;
        idle(6);
        exp_q = '{8'h43, 8'h07, 8'h03, 8'h42};
        check_log("stall");

        // Move overwritten while cfg emits
        clear_log();
        send_cfg = 1; width = 8'h11; length = 8'h12; color_red = 1;
        tick();
        idle(2);
        move_valid = 1; move_dir = 3'd1; move_last = 0;
        tick();
        move_valid = 1; move_dir = 3'd6; move_last = 0;
        tick();
        idle(10);
        exp_q = '{8'h43, 8'h11, 8'h12, 8'h52, 8'h36};
        check_log("overwrite");
        check("overwrite_drops", 8'(drop_cnt), 8'd1);

        // Reset mid-message
        clear_log();
        send_cfg = 1; width = 8'h44; length = 8'h55; color_red = 1;
        tick();
        idle(2);
        rst = 1;
        tick();
        rst = 0;
        idle(4);
        exp_q = '{8'h43, 8'h44};
        check_log("rst_mid");
        check("rst_mid_busy", 8'(busy), 8'd0);
        clear_log();
        send_start = 1;
        tick();
        idle(4);
        exp_q = '{8'h53};
        check_log("rst_then_start");

        // Request coinciding with reset is ignored
        clear_log();
        rst = 1; send_start = 1;
        tick();
        rst = 0;
        idle(4);
        exp_q = {};
        check_log("rst_req");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            send_start = ($urandom_range(9) == 0);
            send_cfg   = ($urandom_range(7) == 0);
            move_valid = ($urandom_range(5) == 0);
            width      = 8'($urandom);
            length     = 8'($urandom);
            color_red  = 1'($urandom);
            move_dir   = 3'($urandom);
            move_last  = 1'($urandom);
            buf_full   = ($urandom_range(3) == 0);
            rst        = ($urandom_range(199) == 0);
            tick();
        end
        rst = 0;
        buf_full = 0;
        idle(30);
        check("final_busy", 8'(busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
